// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store unit.
// Turns an EX/MEM load or store into a single request/grant/response
// transaction on the data-memory port. It produces lane-aligned store data
// and byte enables, and extends load data for writeback. The pipeline is
// stalled while a transaction is in flight.
module mem_access_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ValidM_i,
   input  logic                  MemReadM_i,
   input  logic                  MemWriteM_i,
   input  logic [2:0]            MemCtrlM_i,
   input  logic [DATA_WIDTH-1:0] ALUResultM_i,
   input  logic [DATA_WIDTH-1:0] WriteDataM_i,
   output logic                  dmem_req_o,
   output logic                  dmem_we_o,
   output logic [DATA_WIDTH-1:0] dmem_addr_o,
   output logic [3:0]            dmem_be_o,
   output logic [DATA_WIDTH-1:0] dmem_wdata_o,
   input  logic                  dmem_gnt_i,
   input  logic                  dmem_rvalid_i,
   input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
   output logic [DATA_WIDTH-1:0] ReadDataM_o,
   output logic                  LoadDoneM_o,
   output logic                  StallM_o,
   output logic                  MemErrM_o
);

   // funct3 encodings of the supported access sizes
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_next;

   // decode of the instruction currently presented by EX/MEM
   logic w_access;
   logic w_both;
   logic w_f3_illegal;
   logic w_misaligned;
   logic w_err;
   logic w_start;

   // request fields computed from the incoming instruction
   logic [3:0]            w_be;
   logic [DATA_WIDTH-1:0] w_wdata;

   // transaction fields captured when the access is accepted
   logic [DATA_WIDTH-1:0] r_addr;
   logic [3:0]            r_be;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_we;
   logic [2:0]            r_funct3;
   logic [1:0]            r_off;

   // load result path
   logic [3:0][7:0]       w_lane;
   logic [7:0]            w_byte;
   logic [15:0]           w_half;
   logic [DATA_WIDTH-1:0] w_load_ext;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_load_done;

   // Classify the incoming instruction: real access, illegal size code,
   // or an address that does not fit the access size.
   always_comb begin
      w_access = ValidM_i & (MemReadM_i ^ MemWriteM_i);
      w_both   = ValidM_i & MemReadM_i & MemWriteM_i;
      case (MemCtrlM_i)
         F3_B, F3_H, F3_W: w_f3_illegal = 1'b0;
         F3_BU, F3_HU:     w_f3_illegal = MemWriteM_i;
         default:          w_f3_illegal = 1'b1;
      endcase
      w_misaligned = ((MemCtrlM_i[1:0] == 2'b01) & ALUResultM_i[0])
                   | ((MemCtrlM_i[1:0] == 2'b10) & (ALUResultM_i[1:0] != 2'b00));
      w_err   = (w_access & (w_f3_illegal | w_misaligned)) | w_both;
      w_start = w_access & ~w_err;
   end

   // Byte enables and lane replication of store data by access size.
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = WriteDataM_i;
      case (MemCtrlM_i[1:0])
         2'b00: begin
            w_be    = 4'b0001 << ALUResultM_i[1:0];
            w_wdata = {4{WriteDataM_i[7:0]}};
         end
         2'b01: begin
            w_be    = ALUResultM_i[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{WriteDataM_i[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = WriteDataM_i;
         end
      endcase
   end

   // split the returned word into byte lanes
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign w_lane[gi] = dmem_rdata_i[8*gi +: 8];
      end
   endgenerate

   // Pick the addressed byte/half from the returned word and extend it.
   always_comb begin
      w_byte = w_lane[r_off];
      w_half = r_off[1] ? {w_lane[3], w_lane[2]} : {w_lane[1], w_lane[0]};
      case (r_funct3)
         F3_B:    w_load_ext = {{24{w_byte[7]}}, w_byte};
         F3_H:    w_load_ext = {{16{w_half[15]}}, w_half};
         F3_BU:   w_load_ext = {24'd0, w_byte};
         F3_HU:   w_load_ext = {16'd0, w_half};
         default: w_load_ext = dmem_rdata_i;
      endcase
   end

   // State register; reset abandons any transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: grant only matters in REQ, rvalid only in RESP.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               w_state_next = S_REQ;
            end
         end
         S_REQ: begin
            if (dmem_gnt_i) begin
               w_state_next = r_we ? S_DONE : S_RESP;
            end
         end
         S_RESP: begin
            if (dmem_rvalid_i) begin
               w_state_next = S_DONE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // FSM outputs: request strobe, pipeline stall and error pulse.
   always_comb begin
      dmem_req_o = 1'b0;
      StallM_o   = 1'b0;
      MemErrM_o  = 1'b0;
      case (r_state)
         S_IDLE: begin
            StallM_o  = w_start;
            MemErrM_o = w_err;
         end
         S_REQ: begin
            dmem_req_o = 1'b1;
            StallM_o   = 1'b1;
         end
         S_RESP: begin
            StallM_o = 1'b1;
         end
         default: begin
            StallM_o = 1'b0;
         end
      endcase
   end

   // Capture the request fields once, so the memory port sees them from
   // flops only and they stay stable while a grant is awaited.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr   <= '0;
         r_be     <= '0;
         r_wdata  <= '0;
         r_we     <= 1'b0;
         r_funct3 <= '0;
         r_off    <= '0;
      end else if ((r_state == S_IDLE) && w_start) begin
         r_addr   <= {ALUResultM_i[DATA_WIDTH-1:2], 2'b00};
         r_be     <= w_be;
         r_wdata  <= w_wdata;
         r_we     <= MemWriteM_i;
         r_funct3 <= MemCtrlM_i;
         r_off    <= ALUResultM_i[1:0];
      end
   end

   // Register the extended load result; it holds until the next load
   // completes, and the done pulse lands in the DONE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata     <= '0;
         r_load_done <= 1'b0;
      end else begin
         r_load_done <= (r_state == S_RESP) & dmem_rvalid_i;
         if ((r_state == S_RESP) && dmem_rvalid_i) begin
            r_rdata <= w_load_ext;
         end
      end
   end

   assign dmem_we_o    = r_we;
   assign dmem_addr_o  = r_addr;
   assign dmem_be_o    = r_be;
   assign dmem_wdata_o = r_wdata;
   assign ReadDataM_o  = r_rdata;
   assign LoadDoneM_o  = r_load_done;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized transactions against a
// behavioural model of the load/store unit, with the bench acting as the
// data memory (configurable grant and rvalid latency, stray handshakes).
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ValidM_i;
   logic        MemReadM_i;
   logic        MemWriteM_i;
   logic [2:0]  MemCtrlM_i;
   logic [31:0] ALUResultM_i;
   logic [31:0] WriteDataM_i;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_wdata_o;
   logic        dmem_gnt_i;
   logic        dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;
   logic [31:0] ReadDataM_o;
   logic        LoadDoneM_o;
   logic        StallM_o;
   logic        MemErrM_o;

   int n_vec  = 0;
   int n_fail = 0;
   logic [31:0] exp_rd = 32'd0;   // model of ReadDataM_o

   always #5 clk = ~clk;

   mem_access_unit #(.DATA_WIDTH(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ValidM_i     (ValidM_i),
      .MemReadM_i   (MemReadM_i),
      .MemWriteM_i  (MemWriteM_i),
      .MemCtrlM_i   (MemCtrlM_i),
      .ALUResultM_i (ALUResultM_i),
      .WriteDataM_i (WriteDataM_i),
      .dmem_req_o   (dmem_req_o),
      .dmem_we_o    (dmem_we_o),
      .dmem_addr_o  (dmem_addr_o),
      .dmem_be_o    (dmem_be_o),
      .dmem_wdata_o (dmem_wdata_o),
      .dmem_gnt_i   (dmem_gnt_i),
      .dmem_rvalid_i(dmem_rvalid_i),
      .dmem_rdata_i (dmem_rdata_i),
      .ReadDataM_o  (ReadDataM_o),
      .LoadDoneM_o  (LoadDoneM_o),
      .StallM_o     (StallM_o),
      .MemErrM_o    (MemErrM_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int size_of(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         2'b10:   return 4;
         default: return 0;
      endcase
   endfunction

   function automatic bit model_err(input logic v, rd, wr, input logic [2:0] f3, input logic [31:0] a);
      int sz;
      if (!v) return 1'b0;
      if (rd && wr) return 1'b1;
      if (!rd && !wr) return 1'b0;
      if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
      if (wr && f3 >= 3'd4) return 1'b1;
      sz = size_of(f3);
      return (int'(a[1:0]) % sz) != 0;
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
      int sz = size_of(f3);
      int off = int'(a[1:0]);
      return 4'(((1 << sz) - 1) << off);
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
      int sz = size_of(f3);
      logic [31:0] r = 32'd0;
      for (int i = 0; i < 4; i++) begin
         r = r | (((wd >> (8 * (i % sz))) & 32'hFF) << (8 * i));
      end
      return r;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdat);
      int sz = size_of(f3);
      logic [31:0] v = rdat >> (8 * int'(a[1:0]));
      logic [31:0] mask;
      if (sz == 4) return rdat;
      mask = (32'd1 << (8 * sz)) - 32'd1;
      v = v & mask;
      if (!f3[2] && v[8*sz-1]) v = v | ~mask;
      return v;
   endfunction

   // ---------------- one pipeline instruction ----------------
   task automatic run_access(input string tag, input logic v, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rdat, input int gd, input int rvd, input bit stray);
      bit err = model_err(v, rd, wr, f3, a);
      bit acc = v && (rd ^ wr);
      bit go  = acc && !err;
      bit ld  = go && rd;
      logic [31:0] e_addr = {a[31:2], 2'b00};
      logic [3:0]  e_be = 4'd0;
      logic [31:0] e_wd = 32'd0;
      int e_stall = go ? (2 + gd + (ld ? 1 + rvd : 0)) : 0;
      int n_stall = 0, n_req = 0, n_err = 0, n_done = 0;
      int req_seen = 0, resp_wait = 0;
      bit gnt_done = 0, rv_done = 0, finished = 0, in_resp;
      logic gnt_now, rv_now;
      if (go) begin
         e_be = model_be(f3, a);
         e_wd = model_wdata(f3, wd);
      end
      for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
         @(posedge clk);
         #1;
         ValidM_i     = v;
         MemReadM_i   = rd;
         MemWriteM_i  = wr;
         MemCtrlM_i   = f3;
         ALUResultM_i = a;
         WriteDataM_i = wd;
         in_resp = ld && gnt_done && !rv_done;
         gnt_now = dmem_req_o && (req_seen >= gd);
         if (!dmem_req_o && stray) gnt_now = 1'($urandom_range(0, 1));
         rv_now = in_resp ? (resp_wait == rvd) : (stray && ($urandom_range(0, 2) == 0));
         dmem_gnt_i    = gnt_now;
         dmem_rvalid_i = rv_now;
         dmem_rdata_i  = (in_resp && rv_now) ? rdat : $urandom;
         @(negedge clk);
         n_stall += int'(StallM_o);
         n_err   += int'(MemErrM_o);
         n_done  += int'(LoadDoneM_o);
         if (dmem_req_o) begin
            n_req++;
            check({tag, ".addr"}, dmem_addr_o, e_addr);
            check({tag, ".be"}, {28'd0, dmem_be_o}, {28'd0, e_be});
            check({tag, ".we"}, {31'd0, dmem_we_o}, {31'd0, wr});
            if (wr) check({tag, ".wdata"}, dmem_wdata_o, e_wd);
         end
         if (in_resp) begin
            if (rv_now) rv_done = 1;
            else resp_wait++;
         end
         if (gnt_now && dmem_req_o) gnt_done = 1;
         if (dmem_req_o) req_seen++;
         if (!StallM_o) finished = 1;
      end
      if (ld) exp_rd = model_load(f3, a, rdat);
      check({tag, ".finished"}, {31'd0, finished}, 32'd1);
      check({tag, ".stall_cycles"}, n_stall, e_stall);
      check({tag, ".req_cycles"}, n_req, go ? 1 + gd : 0);
      check({tag, ".err_pulses"}, n_err, {31'd0, err});
      check({tag, ".done_pulses"}, n_done, {31'd0, ld});
      check({tag, ".rdata"}, ReadDataM_o, exp_rd);
      $display("%s: v=%0d rd=%0d wr=%0d f3=%0d addr=%h wd=%h gd=%0d rvd=%0d stall=%0d rdata=%h",
               tag, v, rd, wr, f3, a, wd, gd, rvd, n_stall, ReadDataM_o);
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      ValidM_i = 1'b0; MemReadM_i = 1'b0; MemWriteM_i = 1'b0;
      MemCtrlM_i = 3'd0; ALUResultM_i = 32'd0; WriteDataM_i = 32'd0;
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'd0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst.req",   {31'd0, dmem_req_o}, 32'd0);
      check("rst.we",    {31'd0, dmem_we_o}, 32'd0);
      check("rst.addr",  dmem_addr_o, 32'd0);
      check("rst.be",    {28'd0, dmem_be_o}, 32'd0);
      check("rst.wdata", dmem_wdata_o, 32'd0);
      check("rst.rdata", ReadDataM_o, 32'd0);
      check("rst.done",  {31'd0, LoadDoneM_o}, 32'd0);
      check("rst.err",   {31'd0, MemErrM_o}, 32'd0);
      check("rst.stall", {31'd0, StallM_o}, 32'd0);
      $display("reset: req=%0d rdata=%h", dmem_req_o, ReadDataM_o);
      rst_n = 1'b1;

      // directed cases
      run_access("sw_104", 1, 0, 1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 0, 0, 0);
      run_access("sb_203", 1, 0, 1, 3'b000, 32'h203, 32'h000000A5, 32'h0, 0, 0, 0);
      run_access("lb_101", 1, 1, 0, 3'b000, 32'h101, 32'h0, 32'h000080FF, 2, 3, 0);
      check("lb_101.const", ReadDataM_o, 32'hFFFFFF80);
      run_access("lhu_102", 1, 1, 0, 3'b101, 32'h102, 32'h0, 32'hBEEF1234, 0, 0, 0);
      check("lhu_102.const", ReadDataM_o, 32'h0000BEEF);
      run_access("lh_102", 1, 1, 0, 3'b001, 32'h102, 32'h0, 32'hBEEF1234, 1, 0, 0);
      check("lh_102.const", ReadDataM_o, 32'hFFFFBEEF);
      run_access("lw_mis", 1, 1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0, 0);
      run_access("f3_011", 1, 1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 0);
      run_access("sbu_ill", 1, 0, 1, 3'b100, 32'h100, 32'h11, 32'h0, 0, 0, 0);
      run_access("rd_wr", 1, 1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 0, 0, 0);
      check("rd_wr.rdata_held", ReadDataM_o, 32'hFFFFBEEF);

      // reset while the load waits in RESP, then a stray rvalid
      @(posedge clk); #1;
      ValidM_i = 1'b1; MemReadM_i = 1'b1; MemWriteM_i = 1'b0;
      MemCtrlM_i = 3'b010; ALUResultM_i = 32'h300;
      @(posedge clk); #1;   // REQ
      dmem_gnt_i = 1'b1;
      @(posedge clk); #1;   // RESP
      dmem_gnt_i = 1'b0;
      ValidM_i = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      exp_rd = 32'd0;
      check("rstm.req",   {31'd0, dmem_req_o}, 32'd0);
      check("rstm.rdata", ReadDataM_o, exp_rd);
      check("rstm.stall", {31'd0, StallM_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         dmem_rvalid_i = 1'b1;
         dmem_rdata_i  = 32'h12345678;
         @(negedge clk);
         check("rstm.done",  {31'd0, LoadDoneM_o}, 32'd0);
         check("rstm.hold",  ReadDataM_o, exp_rd);
         check("rstm.idle",  {31'd0, StallM_o | dmem_req_o}, 32'd0);
         $display("rst_mid: cycle %0d done=%0d rdata=%h", i, LoadDoneM_o, ReadDataM_o);
      end
      dmem_rvalid_i = 1'b0;

      // randomized traffic with stray handshakes
      for (int t = 0; t < 250; t++) begin
         logic rv, rr, rw;
         logic [2:0] rf;
         logic [31:0] ra, rwd, rrd;
         rv  = ($urandom_range(0, 7) != 0);
         rr  = 1'($urandom_range(0, 1));
         rw  = ($urandom_range(0, 5) == 0) ? rr : ~rr;
         rf  = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) rf = (rf[2] && rr) ? {1'b1, 1'b0, rf[0]} : {1'b0, rf[1] & ~rf[0], rf[0] & ~rf[1]};
         ra  = $urandom;
         rwd = $urandom;
         rrd = $urandom;
         run_access("rnd", rv, rr, rw, rf, ra, rwd, rrd,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit sitting directly downstream of the execute stage (behind the EX/MEM pipeline register). It takes the ALU result as the byte address and the register write data from execute. It runs a request/grant/response handshake with the data memory and produces sign- or zero-extended load data for writeback. The pipeline is stalled while an access is outstanding.

## Interface
- DATA_WIDTH, 32, data/address width (the unit supports 32 only)
- clk  input  1  clock
- rst_n  input  1  asynchronous, active-low reset
- ValidM_i  input  1  EX/MEM slot holds a live instruction
- MemReadM_i  input  1  instruction is a load
- MemWriteM_i  input  1  instruction is a store
- MemCtrlM_i  input  3  funct3 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ALUResultM_i  input  32  byte address from execute
- WriteDataM_i  input  32  store data (rs2) from execute
- dmem_req_o  output  1  request valid
- dmem_we_o  output  1  1 = write
- dmem_addr_o  output  32  word-aligned address ({addr[31:2],2'b00})
- dmem_be_o  output  4  byte enables
- dmem_wdata_o  output  32  lane-aligned write data
- dmem_gnt_i  input  1  memory accepts the request this cycle
- dmem_rvalid_i  input  1  read data valid
- dmem_rdata_i  input  32  read word
- ReadDataM_o  output  32  extended load result (registered)
- LoadDoneM_o  output  1  one-cycle pulse: ReadDataM_o updated
- StallM_o  output  1  hold the EX/MEM register and all earlier stages
- MemErrM_o  output  1  one-cycle pulse: misaligned or illegal access

## Operation
- access = ValidM_i & (MemReadM_i ^ MemWriteM_i).
- err = access & (illegal funct3 | misaligned).
  - Illegal funct3 is 011/110/111, plus 100/101 on a store.
  - Misaligned is H with addr[0]=1, or W with addr[1:0]≠00.
- MemReadM_i & MemWriteM_i both high with ValidM_i is treated as err.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - access & !err: latch the address, be, wdata, we, funct3 and addr[1:0]; go to REQ.
  - err: pulse MemErrM_o, issue no request, no stall, stay in IDLE.
  - Otherwise stay in IDLE.
- REQ:
  - dmem_req_o=1 with the latched fields.
  - On dmem_gnt_i: store → DONE; load → RESP.
  - Without a grant, hold the request with all fields stable.
- RESP:
  - On dmem_rvalid_i: register the extended data into ReadDataM_o, pulse LoadDoneM_o next cycle (in DONE), go to DONE.
- DONE: ignore all inputs; go to IDLE.
- StallM_o = (IDLE & access & !err) | REQ | RESP. It is 0 in DONE, so the pipeline advances at the end of DONE.
- Byte enables and write data:
  - B: be = 0001 << addr[1:0]; wdata = {4{wd[7:0]}}.
  - H: be = 0011 or 1100 by addr[1]; wdata = {2{wd[15:0]}}.
  - W: be = 1111; wdata = wd.
- Load extraction:
  - Select the byte at rdata[8*addr[1:0] +: 8], or the half at rdata[16*addr[1] +: 16].
  - Sign-extend for B/H; zero-extend for BU/HU.
- ReadDataM_o holds its value until the next completed load.
- dmem_rvalid_i outside RESP and dmem_gnt_i outside REQ are ignored.

## Timing
- Reset (rst_n=0, asynchronous) forces:
  - state=IDLE;
  - dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, ReadDataM_o all 0;
  - LoadDoneM_o, MemErrM_o 0.
- Reset mid-access drops dmem_req_o immediately, abandons the transaction and discards any later rvalid.
- Request outputs are driven from registers only. Nothing is combinational from inputs to dmem_*.
- StallM_o is combinational from the inputs in IDLE.
- Store latency, with immediate grant: 3 cycles stalled-or-done (IDLE, REQ, DONE); StallM_o high for 2 cycles.
- Load latency, with grant and rvalid each in the first possible cycle: 4 cycles; ReadDataM_o valid in DONE.
- Each cycle of grant or rvalid wait adds exactly one stall cycle.
- Back-to-back accesses: the next access is recognised in the IDLE cycle after DONE. Minimum spacing is 3 cycles per store.
- MemErrM_o is asserted in the same cycle as the offending IDLE input; registered version: no, combinational pulse.

## Test plan
- SW addr 0x104, data 0xDEADBEEF, gnt on first REQ cycle → one request: addr 0x104, be 1111, wdata 0xDEADBEEF, we=1; StallM_o high 2 cycles.
- SB addr 0x203, data 0x000000A5 → be 1000, wdata 0xA5A5A5A5, addr 0x200.
- LB addr 0x101, rdata 0x0000_80FF (grant delayed 2 cycles, rvalid 3 cycles later) → ReadDataM_o 0xFFFFFF80; LoadDoneM_o pulses in DONE; stall spans every wait cycle.
- LHU addr 0x102, rdata 0xBEEF1234 → 0x0000BEEF. LH of the same → 0xFFFFBEEF.
- LW addr 0x102 → MemErrM_o=1 for one cycle, no dmem_req_o, StallM_o=0. Funct3 011 gives the same result.
- rst_n pulled low in RESP, then released, with a stray rvalid → state IDLE, ReadDataM_o=0, no LoadDoneM_o pulse.
